dezigzag: RTL and testbench



---
 rtl/jpeg_pkg.sv | 32 +++
 rtl/dezigzag_bank.sv | 22 ++
 rtl/dezigzag.sv | 103 ++++++++++
 tb/tb_dezigzag.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG block constants and the zigzag <-> natural-order mapping,
// used by both the decode-side dezigzag and the encode-side zigzag.
package jpeg_pkg;

    localparam int unsigned BLK_SIZE = 64;

    // Entry k is the natural (row-major) address of zigzag position k.
    localparam logic [5:0] ZZ_TABLE [BLK_SIZE] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz2nat(input logic [5:0] k);
        return ZZ_TABLE[k];
    endfunction

    function automatic logic [5:0] nat2zz(input logic [5:0] a);
        logic [5:0] r;
        r = '0;
        for (int unsigned i = 0; i < BLK_SIZE; i++) begin
            if (ZZ_TABLE[i] == a) r = 6'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/dezigzag_bank.sv
// One ping-pong bank: 64-word single-port RAM, either written or read per cycle,
// synchronous read with one cycle of latency.
module dezigzag_bank
    import jpeg_pkg::*;
#(
    parameter int unsigned DATA_W = 42
) (
    input  logic              clk,
    input  logic              we,
    input  logic [5:0]        addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [BLK_SIZE];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        else    dout      <= mem[addr];
    end

endmodule

// File: rtl/dezigzag.sv
// Inverse zigzag reorder: zigzag-ordered coefficient blocks in, block order out,
// through two ping-pong banks and a 2-entry output FIFO that absorbs read latency.
module dezigzag
    import jpeg_pkg::*;
#(
    parameter int unsigned DATA_W    = 42,
    parameter bit          COL_MAJOR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    logic [5:0]        wr_cnt, rd_cnt;
    logic              wr_bank, rd_bank;
    logic [1:0]        full;
    logic              inflight, inflight_bank, inflight_last;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              fifo_head;
    logic [1:0]        fifo_count;
    logic              fifo_tail;
    logic              wr_fire, rd_fire, pop, push;
    logic [1:0]        count_after_pop;
    logic [5:0]        wr_addr, rd_addr;
    logic [1:0]        we;
    logic [DATA_W-1:0] dout [2];

    assign in_ready        = ~full[wr_bank];
    assign wr_fire         = in_valid & in_ready;
    assign out_valid       = (fifo_count != 2'd0);
    assign pop             = out_valid & out_ready;
    assign push            = inflight;
    assign count_after_pop = fifo_count - {1'b0, pop};
    // Counting the in-flight read keeps the FIFO from ever overflowing.
    assign rd_fire         = full[rd_bank] && ((count_after_pop + {1'b0, inflight}) < 2'd2);
    assign wr_addr         = zz2nat(wr_cnt);
    assign rd_addr         = COL_MAJOR ? {rd_cnt[2:0], rd_cnt[5:3]} : rd_cnt;
    assign we              = {wr_fire & wr_bank, wr_fire & ~wr_bank};
    // With two entries the tail is the head when empty or full, else the other slot.
    assign fifo_tail       = fifo_head ^ fifo_count[0];
    assign out_data        = fifo_data[fifo_head];
    assign out_last        = fifo_last[fifo_head];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dezigzag_bank #(.DATA_W(DATA_W)) u_bank (
            .clk  (clk),
            .we   (we[b]),
            .addr (we[b] ? wr_addr : rd_addr),
            .din  (in_data),
            .dout (dout[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            full          <= '0;
            inflight      <= 1'b0;
            inflight_bank <= 1'b0;
            inflight_last <= 1'b0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_last     <= '0;
            fifo_head     <= 1'b0;
            fifo_count    <= '0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 6'd1;
                if (wr_cnt == 6'd63) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 6'd1;
                if (rd_cnt == 6'd63) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
            inflight      <= rd_fire;
            inflight_bank <= rd_bank;
            inflight_last <= (rd_cnt == 6'd63);
            if (push) begin
                fifo_data[fifo_tail] <= dout[inflight_bank];
                fifo_last[fifo_tail] <= inflight_last;
            end
            if (pop) fifo_head <= ~fifo_head;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_dezigzag.sv
// Scoreboard bench for dezigzag: column-major and row-major instances share one
// input stream and output handshake; expected blocks come from a local inverse table.
module tb_dezigzag;
    import jpeg_pkg::*;

    localparam int unsigned DW = 42;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, in_ready_rm;
    logic [DW-1:0] out_data, out_data_rm;
    logic          out_valid, out_valid_rm, out_last, out_last_rm;

    dezigzag #(.DATA_W(DW), .COL_MAJOR(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    dezigzag #(.DATA_W(DW), .COL_MAJOR(1'b0)) dut_rm (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_rm),
        .out_data(out_data_rm), .out_valid(out_valid_rm), .out_ready(out_ready), .out_last(out_last_rm)
    );

    always #5 clk = ~clk;

    // Zigzag index of each natural (row-major) position.
    logic [5:0] nz_tab [64] = '{
        6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
        6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
        6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
        6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
        6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
        6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
        6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
        6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
    };
    int first_col [6] = '{0, 2, 3, 9, 10, 20};
    int first_row [8] = '{0, 1, 5, 6, 14, 15, 27, 28};

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_col [$];
    logic [DW-1:0] exp_row [$];
    logic          exp_last [$];
    logic [DW-1:0] blk [64];
    logic [DW-1:0] cur_data = '0;
    int            n_in = 0, n_out = 0, n_last = 0, wcount = 0, cyc = 0;
    int            last_in_cyc = -1, first_out_cyc = -1;
    int            first_pop_cyc = -1, last_pop_cyc = -1, in_stall = 0;
    logic          prev_stall = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called once per cycle at the falling edge: scoreboard both handshakes.
    task automatic sample();
        logic [DW-1:0] ec, er;
        logic          el;
        logic [5:0]    jj, a;
        if (rst) begin
            exp_col.delete(); exp_row.delete(); exp_last.delete();
            wcount = 0;
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            check("stall_valid", DW'(out_valid), DW'(1));
            check("stall_data", out_data, prev_data);
            check("stall_last", DW'(out_last), DW'(prev_last));
        end
        if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        if (in_valid && !in_ready) in_stall++;
        if (out_valid && out_ready) begin
            check("queue_nonempty", DW'(exp_col.size() != 0), DW'(1));
            check("rm_valid", DW'(out_valid_rm), DW'(1));
            if (exp_col.size() != 0) begin
                ec = exp_col.pop_front(); er = exp_row.pop_front(); el = exp_last.pop_front();
                check("col_data", out_data, ec);
                check("row_data", out_data_rm, er);
                check("col_last", DW'(out_last), DW'(el));
                check("row_last", DW'(out_last_rm), DW'(el));
                if (n_out < 6) check("col_first", out_data, DW'(first_col[n_out]));
                if (n_out < 8) check("row_first", out_data_rm, DW'(first_row[n_out]));
            end
            if (out_last) n_last++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            n_out++;
        end
        if (in_valid && in_ready) begin
            check("rm_in_ready", DW'(in_ready_rm), DW'(1));
            blk[wcount] = in_data;
            wcount++;
            n_in++;
            if (wcount == 64) begin
                for (int j = 0; j < 64; j++) begin
                    jj = 6'(j);
                    a  = {jj[2:0], jj[5:3]};
                    exp_col.push_back(blk[nz_tab[a]]);
                    exp_row.push_back(blk[nz_tab[jj]]);
                    exp_last.push_back(j == 63);
                end
                wcount = 0;
                last_in_cyc = cyc;
            end
            cur_data = (n_in < 128) ? DW'(n_in % 64) : DW'({$urandom(), $urandom()});
        end
        prev_stall = out_valid & ~out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        cyc++;
        @(posedge clk);
        #1;
        in_data = cur_data;
    endtask

    // omode: 0 = out_ready high, 1 = random 50%, 2 = high one cycle in three.
    task automatic run(input int blocks, input int vpct, input int omode, input string tag);
        int target = n_in + blocks * 64;
        int budget = 0;
        int ph = 0;
        while ((n_in < target || exp_col.size() != 0 || out_valid) && budget < 20000) begin
            in_valid = (n_in < target) && (int'($urandom_range(99)) < vpct);
            case (omode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(1));
                default: out_ready = (ph % 3 == 0);
            endcase
            ph++;
            budget++;
            tick();
        end
        in_valid = 1'b0;
        check({tag, "_timeout"}, DW'(budget < 20000), DW'(1));
    endtask

    initial begin
        int k, t, n0, l0;

        for (int a = 0; a < 64; a++) begin
            check("pkg_nat2zz", DW'(nat2zz(6'(a))), DW'(nz_tab[a]));
            check("pkg_zz2nat", DW'(zz2nat(nz_tab[a])), DW'(a));
        end

        tick(); tick();
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_last", DW'(out_last), DW'(0));
        check("rst_out_data", out_data, DW'(0));
        check("rst_in_ready", DW'(in_ready), DW'(1));
        rst = 1'b0;

        run(1, 100, 0, "single");
        check("latency", DW'(first_out_cyc - last_in_cyc), DW'(3));
        check("single_last_count", DW'(n_last), DW'(1));

        first_pop_cyc = -1; in_stall = 0; n0 = n_out;
        run(4, 100, 0, "b2b");
        check("b2b_in_stall", DW'(in_stall), DW'(0));
        check("b2b_continuous", DW'(last_pop_cyc - first_pop_cyc), DW'(255));
        check("b2b_beats", DW'(n_out - n0), DW'(256));

        out_ready = 1'b0; n0 = n_out; l0 = n_last; t = n_in; k = 0;
        while (in_ready && k < 400) begin
            in_valid = 1'b1;
            tick();
            k++;
        end
        in_valid = 1'b0;
        check("full_after_128", DW'(n_in - t), DW'(128));
        run(1, 100, 2, "stall");
        check("stall_beats", DW'(n_out - n0), DW'(192));
        check("stall_last_count", DW'(n_last - l0), DW'(3));

        l0 = n_last;
        run(20, 50, 1, "random");
        check("random_last_count", DW'(n_last - l0), DW'(20));

        out_ready = 1'b0; t = n_in + 94; k = 0;
        while (n_in < t && k < 1000) begin
            in_valid = 1'b1;
            tick();
            k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1; t = n_out + 54; k = 0;
        while (n_out < t && k < 1000) begin
            tick();
            k++;
        end
        out_ready = 1'b0;
        check("pre_rst_pending", DW'(exp_col.size()), DW'(10));
        rst = 1'b1;
        tick();
        check("midrst_out_valid", DW'(out_valid), DW'(0));
        check("midrst_out_last", DW'(out_last), DW'(0));
        check("midrst_out_data", out_data, DW'(0));
        check("midrst_in_ready", DW'(in_ready), DW'(1));
        rst = 1'b0;
        l0 = n_last; n0 = n_out;
        run(1, 100, 0, "post_rst");
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("post_rst_beats", DW'(n_out - n0), DW'(64));
        check("post_rst_last_count", DW'(n_last - l0), DW'(1));
        check("post_rst_idle", DW'(out_valid), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
